// File: rtl/oc8051_ifetch_pkg.sv
// Shared oc8051 instruction-fetch definitions: FSM encodings, reset vector,
// ROM word geometry and a small helper for the consumer handshake.
package oc8051_ifetch_pkg;

    // Fetch FSM encodings
    localparam logic [1:0] StRun     = 2'd0;  // issuing ROM words or external requests
    localparam logic [1:0] StExt     = 2'd1;  // waiting for an external byte
    localparam logic [1:0] StExtDrop = 2'd2;  // waiting for an external byte to discard

    // Program counter value after reset
    localparam logic [15:0] RstVector = 16'h0000;

    // Bytes delivered by one internal ROM read
    localparam logic [2:0] RomWordBytes = 3'd4;

    // A consumed length of zero is treated as a single byte.
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        norm_len = (len == 2'd0) ? 2'd1 : len;
    endfunction

endpackage

// File: rtl/oc8051_ifetch_buf.sv
// Prefetch byte FIFO: push 0/1/4 bytes, pop 0..3 bytes, flush.
// Exposes the three head bytes; bytes beyond the occupancy read as zero.
module oc8051_ifetch_buf
    import oc8051_ifetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [2:0]                   push_cnt,
    input  logic [31:0]                  push_data,
    input  logic [1:0]                   pop_cnt,
    output logic [$clog2(BUF_DEPTH):0]   count,
    output logic [7:0]                   head0,
    output logic [7:0]                   head1,
    output logic [7:0]                   head2
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    logic [7:0]    mem [BUF_DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;

    // Byte storage write; no reset since reads are masked by the occupancy.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < push_cnt) begin
                    mem[wr_q + AW'(i)] <= push_data[8*i +: 8];
                end
            end
        end
    end

    // Read/write pointers and occupancy; flush empties without moving the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= rd_q;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_q + AW'(pop_cnt);
            wr_q  <= wr_q + AW'(push_cnt);
            cnt_q <= cnt_q + (AW+1)'(push_cnt) - (AW+1)'(pop_cnt);
        end
    end

    // Head bytes, zeroed where the FIFO holds nothing valid.
    always_comb begin
        count = cnt_q;
        head0 = (cnt_q > (AW+1)'(0)) ? mem[rd_q]           : 8'h00;
        head1 = (cnt_q > (AW+1)'(1)) ? mem[rd_q + AW'(1)] : 8'h00;
        head2 = (cnt_q > (AW+1)'(2)) ? mem[rd_q + AW'(2)] : 8'h00;
    end

endmodule

// File: rtl/oc8051_ifetch.sv
// oc8051 instruction fetch: prefetches program bytes from the internal ROM
// (4-byte words, one cycle latency) or an external byte bus into a FIFO and
// presents up to three head bytes to the decoder.
module oc8051_ifetch
    import oc8051_ifetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        ea_int,
    output logic [15:0] ext_adr,
    output logic        ext_stb,
    input  logic [7:0]  ext_dat,
    input  logic        ext_ack,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic [1:0]  ins_len,
    output logic [7:0]  ins_op,
    output logic [7:0]  ins_op1,
    output logic [7:0]  ins_op2,
    output logic [15:0] ins_pc
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [15:0] fptr_q, fptr_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ext_adr_q, ext_adr_d;
    logic        inflight_q, inflight_d;

    logic [AW:0] buf_count;
    logic [AW:0] free_bytes;
    logic [1:0]  len;
    logic        pop;
    logic [1:0]  pop_cnt;
    logic        issue_rom;
    logic        issue_ext;
    logic        rom_push;
    logic        ext_push;
    logic [2:0]  push_cnt;
    logic [31:0] push_data;

    // Issue/push/pop decode; jmp suppresses all three in its cycle.
    always_comb begin
        free_bytes = (AW+1)'(BUF_DEPTH) - buf_count;
        ins_valid  = (buf_count >= (AW+1)'(3));
        len        = norm_len(ins_len);
        pop        = ins_valid & ins_ready & ~jmp;
        pop_cnt    = pop ? len : 2'd0;
        // Only one word may be outstanding, so the free-space test never has
        // to account for bytes still on their way back from the ROM.
        issue_rom  = (state_q == StRun) & ea_int & ~inflight_q & ~jmp &
                     (free_bytes >= (AW+1)'(RomWordBytes));
        issue_ext  = (state_q == StRun) & ~ea_int & ~inflight_q & ~jmp &
                     (free_bytes >= (AW+1)'(1));
        // The returning word is discarded when a redirect lands on it.
        rom_push   = inflight_q & ~jmp;
        ext_push   = (state_q == StExt) & ext_ack & ~jmp;
        push_cnt   = rom_push ? RomWordBytes : (ext_push ? 3'd1 : 3'd0);
        push_data  = rom_push ? rom_data : {24'h000000, ext_dat};
    end

    // Fetch FSM and pointer next-state.
    always_comb begin
        state_d    = state_q;
        fptr_d     = fptr_q;
        ext_adr_d  = ext_adr_q;
        inflight_d = issue_rom;
        pc_d       = pc_q + {14'd0, pop_cnt};

        unique case (state_q)
            StRun: begin
                if (issue_rom) begin
                    fptr_d = fptr_q + {13'd0, RomWordBytes};
                end else if (issue_ext) begin
                    ext_adr_d = fptr_q;
                    state_d   = StExt;
                end
            end
            StExt: begin
                if (ext_ack) begin
                    state_d = StRun;
                    if (!jmp) begin
                        fptr_d = fptr_q + 16'd1;
                    end
                end else if (jmp) begin
                    state_d = StExtDrop;
                end
            end
            StExtDrop: begin
                if (ext_ack) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        // Redirect overrides pointer updates; ext_adr keeps the pending request.
        if (jmp) begin
            fptr_d = jmp_addr;
            pc_d   = jmp_addr;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            fptr_q     <= RstVector;
            pc_q       <= RstVector;
            ext_adr_q  <= 16'h0000;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fptr_q     <= fptr_d;
            pc_q       <= pc_d;
            ext_adr_q  <= ext_adr_d;
            inflight_q <= inflight_d;
        end
    end

    // Output mapping.
    always_comb begin
        rom_addr = fptr_q;
        ext_adr  = ext_adr_q;
        ext_stb  = (state_q == StExt) || (state_q == StExtDrop);
        ins_pc   = pc_q;
    end

    oc8051_ifetch_buf #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (jmp),
        .push_cnt (push_cnt),
        .push_data(push_data),
        .pop_cnt  (pop_cnt),
        .count    (buf_count),
        .head0    (ins_op),
        .head1    (ins_op1),
        .head2    (ins_op2)
    );

endmodule
